mac_pot_pe: RTL and testbench

Parametrised power-of-two systolic processing element for the TPU array. It is the successor to the fixed 8-bit shift-accumulate PE. Weights are encoded as {zero, sign, exponent}, activations are signed, and the accumulator is wide with saturating or wrapping arithmetic. It adds valid-qualified operands, an accumulator clear, a sticky overflow flag and a MAC counter. The PE sits in an output-stationary grid: weights flow top-to-bottom, activations flow left-to-right.

---
 rtl/mac_pot_pe.sv | 104 ++++++++++
 tb/tb_mac_pot_pe.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mac_pot_pe.sv
// Power-of-two weight systolic PE: accumulates activation * (+/-2^exp) into a wide
// signed accumulator with saturate-or-wrap overflow, sticky overflow flag and MAC counter.
module mac_pot_pe #(
  parameter int DATA_W   = 8,
  parameter int SHIFT_W  = 3,
  parameter int ACC_W    = 20,
  parameter bit SATURATE = 1'b1,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      up_valid_in,
  input  logic [SHIFT_W+1:0]        up_in,
  input  logic                      left_valid_in,
  input  logic [DATA_W-1:0]         left_in,
  input  logic                      acc_clear,
  output logic                      up_valid_out,
  output logic [SHIFT_W+1:0]        up_out,
  output logic                      left_valid_out,
  output logic [DATA_W-1:0]         left_out,
  output logic signed [ACC_W-1:0]   mat_out,
  output logic                      ovf,
  output logic [CNT_W-1:0]          mac_cnt
);

  // The largest shifted activation must fit the accumulator exactly.
  if (ACC_W < DATA_W + (1 << SHIFT_W)) begin : g_param_check
    $error("mac_pot_pe: ACC_W must be >= DATA_W + 2**SHIFT_W");
  end

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]        CNT_MAX = {CNT_W{1'b1}};

  logic               w_zero;
  logic               w_sign;
  logic [SHIFT_W-1:0] w_exp;
  logic               fire;

  assign w_zero = up_in[SHIFT_W+1];
  assign w_sign = up_in[SHIFT_W];
  assign w_exp  = up_in[SHIFT_W-1:0];
  assign fire   = up_valid_in & left_valid_in;

  // One guard bit above ACC_W keeps both the product and the running sum exact.
  logic signed [ACC_W:0] left_ext;
  logic signed [ACC_W:0] shifted;
  logic signed [ACC_W:0] product;
  logic signed [ACC_W:0] sum;
  logic                  sum_ovf;

  assign left_ext = {{(ACC_W+1-DATA_W){left_in[DATA_W-1]}}, left_in};
  assign shifted  = left_ext <<< w_exp;
  assign product  = w_zero ? '0 : (w_sign ? -shifted : shifted);
  assign sum      = {mat_out[ACC_W-1], mat_out} + product;
  assign sum_ovf  = sum[ACC_W] ^ sum[ACC_W-1];

  logic signed [ACC_W-1:0] mat_nxt;
  logic                    ovf_nxt;
  logic [CNT_W-1:0]        cnt_nxt;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    mat_nxt = mat_out;
    ovf_nxt = ovf;
    cnt_nxt = mac_cnt;
    if (acc_clear) begin
      ovf_nxt = 1'b0;
      mat_nxt = fire ? product[ACC_W-1:0] : '0;
      cnt_nxt = fire ? CNT_W'(1) : '0;
    end else if (fire) begin
      if (mac_cnt != CNT_MAX) cnt_nxt = mac_cnt + CNT_W'(1);
      if (sum_ovf) begin
        ovf_nxt = 1'b1;
        if (SATURATE) mat_nxt = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        else          mat_nxt = sum[ACC_W-1:0];
      end else begin
        mat_nxt = sum[ACC_W-1:0];
      end
    end
  end

  // NOTE: state uses non-blocking assignments so all registers sample the same pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      up_valid_out   <= 1'b0;
      up_out         <= '0;
      left_valid_out <= 1'b0;
      left_out       <= '0;
      mat_out        <= '0;
      ovf            <= 1'b0;
      mac_cnt        <= '0;
    end else begin
      up_valid_out   <= up_valid_in;
      up_out         <= up_in;
      left_valid_out <= left_valid_in;
      left_out       <= left_in;
      mat_out        <= mat_nxt;
      ovf            <= ovf_nxt;
      mac_cnt        <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_mac_pot_pe.sv
// Self-checking bench for mac_pot_pe: saturating and wrapping instances share stimulus
// and are compared against an arithmetic reference model.
module tb_mac_pot_pe;

  localparam int DATA_W  = 8;
  localparam int SHIFT_W = 3;
  localparam int ACC_W   = 20;
  localparam int CNT_W   = 8;
  localparam longint ACC_MAX = (longint'(1) << (ACC_W-1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) << (ACC_W-1));
  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                up_valid_in = 1'b0;
  logic [SHIFT_W+1:0]  up_in = '0;
  logic                left_valid_in = 1'b0;
  logic [DATA_W-1:0]   left_in = '0;
  logic                acc_clear = 1'b0;

  logic                       s_up_valid_out, w_up_valid_out;
  logic [SHIFT_W+1:0]         s_up_out, w_up_out;
  logic                       s_left_valid_out, w_left_valid_out;
  logic [DATA_W-1:0]          s_left_out, w_left_out;
  logic signed [ACC_W-1:0]    s_mat_out, w_mat_out;
  logic                       s_ovf, w_ovf;
  logic [CNT_W-1:0]           s_mac_cnt, w_mac_cnt;

  mac_pot_pe #(.DATA_W(DATA_W), .SHIFT_W(SHIFT_W), .ACC_W(ACC_W), .SATURATE(1'b1), .CNT_W(CNT_W)) dut_sat (
    .clk(clk), .reset_n(reset_n),
    .up_valid_in(up_valid_in), .up_in(up_in),
    .left_valid_in(left_valid_in), .left_in(left_in), .acc_clear(acc_clear),
    .up_valid_out(s_up_valid_out), .up_out(s_up_out),
    .left_valid_out(s_left_valid_out), .left_out(s_left_out),
    .mat_out(s_mat_out), .ovf(s_ovf), .mac_cnt(s_mac_cnt)
  );

  mac_pot_pe #(.DATA_W(DATA_W), .SHIFT_W(SHIFT_W), .ACC_W(ACC_W), .SATURATE(1'b0), .CNT_W(CNT_W)) dut_wrap (
    .clk(clk), .reset_n(reset_n),
    .up_valid_in(up_valid_in), .up_in(up_in),
    .left_valid_in(left_valid_in), .left_in(left_in), .acc_clear(acc_clear),
    .up_valid_out(w_up_valid_out), .up_out(w_up_out),
    .left_valid_out(w_left_valid_out), .left_out(w_left_out),
    .mat_out(w_mat_out), .ovf(w_ovf), .mac_cnt(w_mac_cnt)
  );

  always #5 clk = ~clk;

  // Reference state; index 0 = saturating instance, 1 = wrapping instance.
  longint m_acc [2];
  bit     m_ovf [2];
  longint m_cnt;
  longint m_uv, m_u, m_lv, m_l;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_acc[i] = 0;
      m_ovf[i] = 1'b0;
    end
    m_cnt = 0;
    m_uv = 0; m_u = 0; m_lv = 0; m_l = 0;
  endtask

  // Applies the behavioural rules for one rising edge using the current inputs.
  task automatic model_edge();
    longint p, s;
    bit     fire;
    fire = up_valid_in && left_valid_in;
    if (up_in[SHIFT_W+1]) p = 0;
    else p = longint'($signed(left_in)) * (longint'(1) << up_in[SHIFT_W-1:0]);
    if (!up_in[SHIFT_W+1] && up_in[SHIFT_W]) p = -p;
    for (int i = 0; i < 2; i++) begin
      if (acc_clear) begin
        m_acc[i] = fire ? p : 0;
        m_ovf[i] = 1'b0;
      end else if (fire) begin
        s = m_acc[i] + p;
        if (s > ACC_MAX || s < ACC_MIN) begin
          m_ovf[i] = 1'b1;
          if (i == 0) s = (s > ACC_MAX) ? ACC_MAX : ACC_MIN;
          else        s = (s > ACC_MAX) ? s - (longint'(1) << ACC_W) : s + (longint'(1) << ACC_W);
        end
        m_acc[i] = s;
      end
    end
    if (acc_clear)  m_cnt = fire ? 1 : 0;
    else if (fire)  m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
    m_uv = up_valid_in; m_u = up_in; m_lv = left_valid_in; m_l = left_in;
  endtask

  task automatic compare_all(input string ph);
    check({ph, ".uv_s"},  s_up_valid_out,   m_uv);
    check({ph, ".up_s"},  s_up_out,         m_u);
    check({ph, ".lv_s"},  s_left_valid_out, m_lv);
    check({ph, ".left_s"},s_left_out,       m_l);
    check({ph, ".uv_w"},  w_up_valid_out,   m_uv);
    check({ph, ".up_w"},  w_up_out,         m_u);
    check({ph, ".lv_w"},  w_left_valid_out, m_lv);
    check({ph, ".left_w"},w_left_out,       m_l);
    check({ph, ".mat_s"}, longint'(s_mat_out), m_acc[0]);
    check({ph, ".mat_w"}, longint'(w_mat_out), m_acc[1]);
    check({ph, ".ovf_s"}, s_ovf, m_ovf[0]);
    check({ph, ".ovf_w"}, w_ovf, m_ovf[1]);
    check({ph, ".cnt_s"}, s_mac_cnt, m_cnt);
    check({ph, ".cnt_w"}, w_mac_cnt, m_cnt);
  endtask

  // Drives one cycle of inputs, advances the model on the edge, checks 1 ns later.
  task automatic drive(input string ph, input bit uv, input logic [SHIFT_W+1:0] u,
                       input bit lv, input logic [DATA_W-1:0] l, input bit clr);
    up_valid_in = uv; up_in = u; left_valid_in = lv; left_in = l; acc_clear = clr;
    @(posedge clk);
    model_edge();
    #1;
    compare_all(ph);
  endtask

  task automatic pulse_reset(input string ph);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    compare_all(ph);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    model_reset();

    // Reset held with toggling inputs.
    for (int i = 0; i < 6; i++) begin
      up_valid_in = 1'($urandom); up_in = (SHIFT_W+2)'($urandom);
      left_valid_in = 1'($urandom); left_in = DATA_W'($urandom); acc_clear = 1'($urandom);
      @(posedge clk);
      #1;
      compare_all("reset_hold");
    end
    @(negedge clk);
    reset_n = 1'b1;
    drive("post_reset", 1'b0, '0, 1'b0, '0, 1'b0);

    // Basic MAC: 5 << 3 = 40.
    drive("basic", 1'b1, {1'b0, 1'b0, 3'd3}, 1'b1, 8'd5, 1'b0);
    check("basic_const_mat", longint'(s_mat_out), 40);
    check("basic_const_cnt", s_mac_cnt, 1);
    drive("basic_idle", 1'b0, '0, 1'b0, '0, 1'b0);

    // Sign, zero flag, single valid.
    drive("neg_w", 1'b1, {1'b0, 1'b1, 3'd2}, 1'b1, -8'sd3, 1'b0);
    check("neg_w_const", longint'(s_mat_out), 52);
    drive("zero_w", 1'b1, {1'b1, 1'b0, 3'd7}, 1'b1, 8'd100, 1'b0);
    check("zero_w_cnt", s_mac_cnt, 3);
    drive("left_only", 1'b0, {1'b0, 1'b0, 3'd4}, 1'b1, 8'd77, 1'b0);
    drive("up_only", 1'b1, {1'b0, 1'b0, 3'd4}, 1'b0, 8'd77, 1'b0);

    // Positive overflow: 33 * 16256.
    drive("clr0", 1'b0, '0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 33; i++) drive("pos_ovf", 1'b1, {1'b0, 1'b0, 3'd7}, 1'b1, 8'd127, 1'b0);
    check("pos_ovf_sat_const", longint'(s_mat_out), 524287);
    check("pos_ovf_wrap_const", longint'(w_mat_out), -512128);
    check("pos_ovf_flag_const", s_ovf, 1);
    check("pos_ovf_cnt_const", s_mac_cnt, 33);

    // Negated most-negative activation: 33 * +16384.
    drive("clr1", 1'b0, '0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 33; i++) drive("neg_neg", 1'b1, {1'b0, 1'b1, 3'd7}, 1'b1, 8'h80, 1'b0);
    check("neg_neg_sat_const", longint'(s_mat_out), 524287);
    check("neg_neg_wrap_const", longint'(w_mat_out), -507904);

    // Clear races.
    drive("clr_fire", 1'b1, {1'b0, 1'b0, 3'd1}, 1'b1, 8'd9, 1'b1);
    check("clr_fire_const", longint'(s_mat_out), 18);
    drive("clr_nofire", 1'b1, {1'b0, 1'b0, 3'd1}, 1'b0, 8'd9, 1'b1);
    drive("pre_rst", 1'b1, {1'b0, 1'b0, 3'd5}, 1'b1, 8'd44, 1'b0);
    pulse_reset("mid_reset");
    drive("after_rst", 1'b0, '0, 1'b0, '0, 1'b0);

    // Random traffic, biased toward high exponents so overflow is reached.
    for (int i = 0; i < 1500; i++) begin
      logic [SHIFT_W+1:0] u;
      u = (SHIFT_W+2)'($urandom);
      if ($urandom_range(0, 3) != 0) u[SHIFT_W-1:0] = SHIFT_W'($urandom_range(5, 7));
      if ($urandom_range(0, 7) != 0) u[SHIFT_W+1] = 1'b0;
      drive("rand", $urandom_range(0, 4) != 0, u, $urandom_range(0, 4) != 0,
            DATA_W'($urandom), $urandom_range(0, 60) == 0);
      if ($urandom_range(0, 300) == 0) pulse_reset("rand_reset");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
